// File: rtl/connect4_pkg.sv
// Shared Connect-4 constants, keycodes and the move-controller state type.
package connect4_pkg;

  localparam int NUM_COLS  = 7;
  localparam int NUM_ROWS  = 6;
  localparam int MAX_MOVES = NUM_COLS * NUM_ROWS;

  localparam logic [7:0] KEY_1     = 8'h1E;
  localparam logic [7:0] KEY_2     = 8'h1F;
  localparam logic [7:0] KEY_3     = 8'h20;
  localparam logic [7:0] KEY_4     = 8'h21;
  localparam logic [7:0] KEY_5     = 8'h22;
  localparam logic [7:0] KEY_6     = 8'h23;
  localparam logic [7:0] KEY_7     = 8'h24;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    HOLDOFF,
    WAIT_REL,
    LOCK
  } move_state_t;

  function automatic logic [NUM_COLS-1:0] col_onehot(input logic [2:0] idx);
    return NUM_COLS'(1) << idx;
  endfunction

endpackage

// File: rtl/move_ctrl_if.sv
// Keyboard/occupancy inputs and drop-command outputs of move_ctrl.
// MOVE_CTRL_CURSOR_EN adds the cursor position signal.
interface move_ctrl_if;
  import connect4_pkg::*;

  logic [7:0]          keycode;
  logic [NUM_COLS-1:0] column_full;
  logic                game_over;
  logic                drop_valid;
  logic [NUM_COLS-1:0] drop_col;
  logic                drop_red;
  logic                turn_red;
  logic                invalid_move;
  logic [5:0]          move_count;
`ifdef MOVE_CTRL_CURSOR_EN
  logic [2:0]          cursor;
`endif

  modport master (
    output keycode, column_full, game_over,
    input  drop_valid, drop_col, drop_red, turn_red, invalid_move, move_count
`ifdef MOVE_CTRL_CURSOR_EN
    , input cursor
`endif
  );

  modport slave (
    input  keycode, column_full, game_over,
    output drop_valid, drop_col, drop_red, turn_red, invalid_move, move_count
`ifdef MOVE_CTRL_CURSOR_EN
    , output cursor
`endif
  );

endinterface

// File: rtl/move_ctrl_key_decoder.sv
// key_decoder: classifies an HID keycode. Navigation/drop keys decode only
// when MOVE_CTRL_CURSOR_EN is defined; otherwise they are plain non-column keys.
module key_decoder
  import connect4_pkg::*;
(
  input  logic [7:0] keycode_i,
  output logic       is_col_o,
  output logic [2:0] col_idx_o,
  output logic       is_left_o,
  output logic       is_right_o,
  output logic       is_drop_o
);

  always_comb begin
    is_col_o   = 1'b0;
    col_idx_o  = 3'd0;
    is_left_o  = 1'b0;
    is_right_o = 1'b0;
    is_drop_o  = 1'b0;
    if (keycode_i >= KEY_1 && keycode_i <= KEY_7) begin
      is_col_o  = 1'b1;
      col_idx_o = 3'(keycode_i - KEY_1);
    end
`ifdef MOVE_CTRL_CURSOR_EN
    is_left_o  = (keycode_i == KEY_LEFT);
    is_right_o = (keycode_i == KEY_RIGHT);
    is_drop_o  = (keycode_i == KEY_ENTER) || (keycode_i == KEY_SPACE);
`endif
  end

endmodule

// File: rtl/move_ctrl.sv
// move_ctrl: turns key presses into single turn-stamped column drop strobes.
// Optional cursor navigation is enabled by defining MOVE_CTRL_CURSOR_EN.
module move_ctrl
  import connect4_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = 8,
  parameter bit FIRST_RED      = 1'b1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  move_ctrl_if.slave bus
);

  localparam int               CNT_W     = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_FRAMES);
  localparam logic [5:0]       MOVES_MAX = 6'(MAX_MOVES);

  move_state_t         state_q, state_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                drop_valid_q, drop_valid_d;
  logic [NUM_COLS-1:0] drop_col_q, drop_col_d;
  logic                drop_red_q, drop_red_d;
  logic                turn_red_q, turn_red_d;
  logic                invalid_q, invalid_d;
  logic [5:0]          move_count_q, move_count_d;
`ifdef MOVE_CTRL_CURSOR_EN
  logic [2:0]          cursor_q, cursor_d;
`endif

  logic       is_col, is_left, is_right, is_drop;
  logic [2:0] col_idx, req_col;

  key_decoder u_dec (
    .keycode_i  (bus.keycode),
    .is_col_o   (is_col),
    .col_idx_o  (col_idx),
    .is_left_o  (is_left),
    .is_right_o (is_right),
    .is_drop_o  (is_drop)
  );

`ifdef MOVE_CTRL_CURSOR_EN
  assign req_col = is_drop ? cursor_q : col_idx;
`else
  assign req_col = col_idx;
`endif

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      drop_valid_q <= 1'b0;
      drop_col_q   <= '0;
      drop_red_q   <= 1'b0;
      turn_red_q   <= FIRST_RED;
      invalid_q    <= 1'b0;
      move_count_q <= '0;
`ifdef MOVE_CTRL_CURSOR_EN
      cursor_q     <= 3'd3;
`endif
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      drop_valid_q <= drop_valid_d;
      drop_col_q   <= drop_col_d;
      drop_red_q   <= drop_red_d;
      turn_red_q   <= turn_red_d;
      invalid_q    <= invalid_d;
      move_count_q <= move_count_d;
`ifdef MOVE_CTRL_CURSOR_EN
      cursor_q     <= cursor_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    drop_valid_d = 1'b0;
    drop_col_d   = '0;
    drop_red_d   = 1'b0;
    turn_red_d   = turn_red_q;
    invalid_d    = 1'b0;
    move_count_d = move_count_q;
`ifdef MOVE_CTRL_CURSOR_EN
    cursor_d     = cursor_q;
`endif
    case (state_q)
      IDLE: begin
        // game_over wins over any key seen on the same edge
        if (bus.game_over) begin
          state_d = LOCK;
        end else if (bus.keycode != 8'h00) begin
          if (is_col || is_drop) begin
`ifdef MOVE_CTRL_CURSOR_EN
            cursor_d = req_col;
`endif
            if (bus.column_full[req_col]) begin
              invalid_d = 1'b1;
              state_d   = WAIT_REL;
            end else begin
              drop_valid_d = 1'b1;
              drop_col_d   = col_onehot(req_col);
              drop_red_d   = turn_red_q;
              state_d      = ISSUE;
            end
          end else if (is_left || is_right) begin
`ifdef MOVE_CTRL_CURSOR_EN
            if (is_left && cursor_q != 3'd0)
              cursor_d = cursor_q - 3'd1;
            else if (is_right && cursor_q != 3'(NUM_COLS - 1))
              cursor_d = cursor_q + 3'd1;
`endif
            state_d = WAIT_REL;
          end else begin
            state_d = WAIT_REL;
          end
        end
      end
      ISSUE: begin
        // The in-flight drop always completes, even if game_over just rose
        turn_red_d = ~turn_red_q;
        if (move_count_q != MOVES_MAX)
          move_count_d = move_count_q + 6'd1;
        if (bus.game_over) begin
          state_d = LOCK;
        end else if (HOLDOFF_FRAMES == 0) begin
          state_d = WAIT_REL;
        end else begin
          hold_cnt_d = HOLD_LOAD;
          state_d    = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (bus.game_over) begin
          hold_cnt_d = '0;
          state_d    = LOCK;
        end else if (hold_cnt_q <= CNT_W'(1)) begin
          hold_cnt_d = '0;
          state_d    = WAIT_REL;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (bus.game_over)
          state_d = LOCK;
        else if (bus.keycode == 8'h00)
          state_d = IDLE;
      end
      LOCK:    state_d = LOCK;
      default: state_d = IDLE;
    endcase
  end

  assign bus.drop_valid   = drop_valid_q;
  assign bus.drop_col     = drop_col_q;
  assign bus.drop_red     = drop_red_q;
  assign bus.turn_red     = turn_red_q;
  assign bus.invalid_move = invalid_q;
  assign bus.move_count   = move_count_q;
`ifdef MOVE_CTRL_CURSOR_EN
  assign bus.cursor       = cursor_q;
`endif

endmodule
